reflector_prog: RTL

//  Run-time rewirable Enigma reflector (UKW-D style) for N letters, one-hot in/out.

---
 rtl/reflector_prog.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/reflector_prog.sv
// ---------------------------------------------------------------------------
// reflector_prog
//
// Run-time rewirable Enigma reflector (UKW-D style) for an N-letter alphabet.
// Letters travel one-hot. A pairing table map[] is held in flops and is always
// a fixed-point-free involution: every letter is paired with exactly one other
// letter, and map[map[i]] == i.
//
// Datapath: one registered lookup per accepted letter (latency 1), with a
// valid/ready handshake on both sides.
//
// Config: a request "pair cfg_a with cfg_b" rewires four table entries in a
// single clock edge. a's old partner pa and b's old partner pb are paired
// with each other, so the table stays an involution.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      input letter valid
//   in_ready   out  1      block accepts a letter this cycle
//   in         in   N      one-hot input letter
//   out_valid  out  1      output letter valid
//   out_ready  in   1      downstream accepts output
//   out        out  N      one-hot reflected letter (0 when out_err)
//   out_err    out  1      qualifies out: input was not one-hot
//   cfg_we     in   1      request: pair cfg_a with cfg_b (sampled in IDLE only)
//   cfg_a      in   IDX_W  letter index A
//   cfg_b      in   IDX_W  letter index B
//   cfg_busy   out  1      rewire in progress
//   cfg_done   out  1      1-cycle pulse: request finished (ok, no-op or error)
//   cfg_err    out  1      1-cycle pulse with cfg_done: request rejected
//   dbg_state  out  2      config FSM state (0 IDLE, 1 READ, 2 WRITE)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready. A producer holding valid keeps its data stable until the
// transfer; out/out_err/out_valid are held while out_valid && !out_ready.
// ---------------------------------------------------------------------------
module reflector_prog #(
    parameter int N     = 26,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out,
    output logic             out_err,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_a,
    input  logic [IDX_W-1:0] cfg_b,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } cfg_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] map_q [N];

    cfg_state_t       state_q;
    cfg_state_t       state_d;
    logic [IDX_W-1:0] a_q;
    logic [IDX_W-1:0] b_q;
    logic [IDX_W-1:0] pa_q;
    logic [IDX_W-1:0] pb_q;
    logic             done_q;
    logic             err_q;

    // ------------------------------------------------------------------
    // Input decode: index of the single set bit, plus a bad flag for a
    // zero or multi-hot letter.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] in_idx;
    logic             in_seen;
    logic             in_multi;
    logic             in_bad;

    always_comb begin
        in_idx   = '0;
        in_seen  = 1'b0;
        in_multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                if (in_seen) begin
                    in_multi = 1'b1;
                end
                in_seen = 1'b1;
                in_idx  = IDX_W'(i);
            end
        end
        in_bad = !in_seen || in_multi;
    end

    // Reflected letter, computed from the table as it stands this cycle.
    logic [N-1:0] lookup_onehot;

    always_comb begin
        lookup_onehot = '0;
        if (!in_bad) begin
            lookup_onehot[map_q[in_idx]] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath handshake and output register
    // ------------------------------------------------------------------
    logic in_fire;

    // Letters are blocked while a rewire is in flight, so no letter can be
    // looked up against a table that is between its old and new contents.
    assign in_ready = !cfg_busy && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_err   <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out       <= lookup_onehot;
            out_err   <= in_bad;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Config request classification (only acted on in IDLE)
    // ------------------------------------------------------------------
    logic             cfg_range_ok;
    logic [IDX_W-1:0] cfg_a_partner;

    assign cfg_range_ok  = (int'(cfg_a) < N) && (int'(cfg_b) < N) && (cfg_a != cfg_b);
    // Muxed so an out-of-range index never drives the comparison.
    assign cfg_a_partner = cfg_range_ok ? map_q[cfg_a] : '0;

    logic start_rewire;
    logic done_d;
    logic err_d;

    always_comb begin
        state_d      = state_q;
        start_rewire = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    if (!cfg_range_ok) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (cfg_a_partner == cfg_b) begin
                        // Already paired: finish immediately without busy.
                        done_d = 1'b1;
                    end else begin
                        state_d      = ST_READ;
                        start_rewire = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (start_rewire) begin
                a_q <= cfg_a;
                b_q <= cfg_b;
            end
            // Old partners captured while the table is still untouched.
            if (state_q == ST_READ) begin
                pa_q <= map_q[a_q];
                pb_q <= map_q[b_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pairing table. a, b, pa, pb are four distinct letters (a != b,
    // a not already paired with b, table is fixed-point free), so the four
    // writes never collide and the result is again an involution.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                map_q[i] <= IDX_W'(i ^ 1);
            end
        end else if (state_q == ST_WRITE) begin
            map_q[a_q]  <= b_q;
            map_q[b_q]  <= a_q;
            map_q[pa_q] <= pb_q;
            map_q[pb_q] <= pa_q;
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign cfg_busy  = (state_q != ST_IDLE);
    // Rewire completion is signalled during WRITE; reject/no-op pulses come
    // from the registered flags one cycle after the request.
    assign cfg_done  = done_q || (state_q == ST_WRITE);
    assign cfg_err   = err_q;
    assign dbg_state = state_q;

endmodule
